// File: rtl/thermo_accumulator.sv
// Sums SAMPLES clamped thermometer counts per window; sum/out_valid appear 1 cycle after the last sample.
// Backpressure: a held result only stalls the window-completing sample; out_ready feeds in_ready combinationally.
module thermo_accumulator #(
  parameter int SAMPLES = 16,
  parameter int OSF     = 8,
  parameter int SUM_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [SUM_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int              CNT_W = (SAMPLES > 2) ? $clog2(SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES - 1);
  localparam logic [3:0]       OSF_V = 4'(OSF);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic             last_sample;
  logic             in_acc;
  logic             take;
  logic             out_acc;
  logic             over_range;
  logic [3:0]       value;
  logic [SUM_W-1:0] acc_plus;

  assign last_sample = (cnt_q == LAST);
  assign in_ready    = ~(last_sample & out_valid_q & ~out_ready);
  assign in_acc      = in_valid & in_ready;
  // A flushed sample is discarded, so it neither sums nor raises err.
  assign take        = in_acc & ~flush;
  assign out_acc     = out_valid_q & out_ready;
  assign over_range  = (in_count > OSF_V);
  assign value       = over_range ? OSF_V : in_count;
  assign acc_plus    = acc_q + SUM_W'(value);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (out_acc) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      if (last_sample) begin
        // Completion overrides a same-cycle output accept: no bubble.
        sum_d       = acc_plus;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_plus;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (take && over_range) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_thermo_accumulator.sv
// Directed bench for thermo_accumulator at SAMPLES=16, OSF=8, SUM_W=8.
module tb_thermo_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_count;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] sum;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  thermo_accumulator #(.SAMPLES(16), .OSF(8), .SUM_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_count  (in_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample, clock it, then settle past the edge.
  task automatic send(input logic [3:0] v);
    in_valid = 1'b1;
    in_count = v;
    flush    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_count = 4'd0;
    flush    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gaps;
    int ovbad;
    logic [3:0] v;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_count  = 4'd7;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Sixteen full-scale samples.
    for (int i = 0; i < 15; i++) send(4'd8);
    chk("full_ov_before_last", out_valid, 0);
    send(4'd8);
    chk("full_sum", sum, 128);
    chk("full_ov", out_valid, 1);
    idle();
    chk("full_ov_one_cycle", out_valid, 0);
    chk("full_sum_holds", sum, 128);
    chk("full_err", err, 0);

    // Triangle pattern over three back-to-back windows.
    gaps  = 0;
    ovbad = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 16; i++) begin
        v = (i <= 8) ? 4'(i) : 4'(16 - i);
        in_valid = 1'b1;
        in_count = v;
        #1;
        if (in_ready !== 1'b1) gaps++;
        @(posedge clk);
        #1;
        if (i == 15) begin
          chk("tri_sum", sum, 64);
          chk("tri_ov", out_valid, 1);
        end else if (out_valid !== 1'b0) begin
          ovbad++;
        end
      end
    end
    chk("tri_ready_gaps", gaps, 0);
    chk("tri_ov_spurious", ovbad, 0);

    // Backpressure: first result held while the second window fills.
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'd3);
    chk("bp_sum1", sum, 48);
    chk("bp_ov1", out_valid, 1);
    for (int i = 0; i < 15; i++) send(4'd5);
    chk("bp_sum1_stable", sum, 48);
    chk("bp_ov1_stable", out_valid, 1);
    in_valid = 1'b1;
    in_count = 4'd5;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    chk("bp_stall_sum", sum, 48);
    chk("bp_stall_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", in_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_sum2", sum, 80);
    chk("bp_ov2", out_valid, 1);
    idle();
    chk("bp_drained", out_valid, 0);

    // Out-of-range sample is clamped and err sticks.
    chk("err_clear_before", err, 0);
    send(4'd12);
    for (int i = 0; i < 15; i++) send(4'd0);
    chk("clamp_sum", sum, 8);
    chk("clamp_err", err, 1);
    for (int i = 0; i < 16; i++) send(4'd1);
    chk("clamp_next_sum", sum, 16);
    chk("err_sticky_window", err, 1);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("err_sticky_flush", err, 1);

    // Flush discards a partial window, including a same-cycle sample.
    for (int i = 0; i < 5; i++) send(4'd4);
    in_valid = 1'b1;
    in_count = 4'd4;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ov_unaffected", out_valid, 0);
    for (int i = 0; i < 15; i++) send(4'd2);
    chk("flush_no_early", out_valid, 0);
    send(4'd2);
    chk("flush_sum", sum, 32);
    chk("flush_ov", out_valid, 1);

    // Reset mid-window with a result pending.
    idle();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(4'd1);
    chk("pend_ov", out_valid, 1);
    for (int i = 0; i < 10; i++) send(4'd6);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_count = 4'd6;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", in_ready, 1);
    for (int i = 0; i < 15; i++) send(4'd1);
    chk("post_rst_no_early", out_valid, 0);
    send(4'd1);
    chk("post_rst_sum", sum, 16);
    chk("post_rst_ov", out_valid, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
